// File: rtl/cls_resp_unit.sv
// ---------------------------------------------------------------------------
// cls_resp_unit
// Response/fault unit for a triple-core lockstep cluster. The master core's
// data request (already compared against the slaves) is forwarded to data
// memory. Grants are returned combinationally to all three cores. Responses
// are returned to all three cores one cycle later.
// Outstanding transactions are tracked. A lockstep mismatch, an unexpected
// response or a response timeout moves the unit into a sticky FAULT state.
// While in FAULT, no new requests are issued.
//
// Ports
//   clk, rst                      : clock (rising edge), async active-high reset
//   data_*_ms                     : master core request (req/we/be/addr/wdata)
//   cmp_fault                     : lockstep comparator mismatch
//   fault_clr                     : request to leave FAULT
//   mem_req/we/be/addr/wdata      : request to data memory
//   mem_gnt/rvalid/rdata          : memory grant and response
//   data_gnt_{ms,sl1,sl2}         : replicated grant
//   data_rvalid_/rdata_{ms,sl1,sl2}: replicated, registered response
//   fault_latched, fault_code     : sticky fault flag and first cause
//   outstanding                   : outstanding transaction count
// ---------------------------------------------------------------------------
module cls_resp_unit #(
    parameter int TIMEOUT = 16,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_ms,
    input  logic        data_we_ms,
    input  logic [3:0]  data_be_ms,
    input  logic [31:0] data_addr_ms,
    input  logic [31:0] data_wdata_ms,
    input  logic        cmp_fault,
    input  logic        fault_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        data_gnt_ms,
    output logic        data_gnt_sl1,
    output logic        data_gnt_sl2,
    output logic        data_rvalid_ms,
    output logic        data_rvalid_sl1,
    output logic        data_rvalid_sl2,
    output logic [31:0] data_rdata_ms,
    output logic [31:0] data_rdata_sl1,
    output logic [31:0] data_rdata_sl2,
    output logic        fault_latched,
    output logic [1:0]  fault_code,
    output logic [1:0]  outstanding
);

    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]  MAX_OUT_C = MAX_OUT[1:0];

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_CMP  = 2'b01;
    localparam logic [1:0] CODE_UNEX = 2'b10;
    localparam logic [1:0] CODE_TMO  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_out, w_out_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;
    logic [1:0]      r_code, w_code_nxt;
    logic            r_fault, w_fault_nxt;
    logic            r_rvalid;
    logic [31:0]     r_rdata;

    logic w_in_fault;
    logic w_accept;
    logic w_rv_counted;
    logic w_unexp;
    logic w_tmo_hit;

    assign w_in_fault = (r_state == ST_FAULT);

    // Request gating: blocked in FAULT, on a live mismatch, or when full.
    assign mem_req   = data_req_ms && !w_in_fault && !cmp_fault && (r_out < MAX_OUT_C);
    assign mem_we    = data_we_ms;
    assign mem_be    = data_be_ms;
    assign mem_addr  = data_addr_ms;
    assign mem_wdata = data_wdata_ms;

    assign w_accept     = mem_req && mem_gnt;
    // A response only retires a transaction if one is actually pending.
    assign w_rv_counted = mem_rvalid && (r_out != 2'd0);
    assign w_unexp      = mem_rvalid && (r_out == 2'd0) && !w_in_fault;
    // The window restarts on an accept, so an accept in the final cycle is not a timeout.
    assign w_tmo_hit    = !w_in_fault && (r_out != 2'd0) && (r_tmo == TMO_LAST)
                          && !mem_rvalid && !w_accept;

    assign data_gnt_ms  = w_accept;
    assign data_gnt_sl1 = w_accept;
    assign data_gnt_sl2 = w_accept;

    assign data_rvalid_ms  = r_rvalid;
    assign data_rvalid_sl1 = r_rvalid;
    assign data_rvalid_sl2 = r_rvalid;
    assign data_rdata_ms   = r_rdata;
    assign data_rdata_sl1  = r_rdata;
    assign data_rdata_sl2  = r_rdata;

    assign fault_latched = r_fault;
    assign fault_code    = r_code;
    assign outstanding   = r_out;

    // Outstanding count and response timeout counter next values.
    always_comb begin
        w_out_nxt = r_out;
        w_tmo_nxt = r_tmo;
        case ({w_accept, w_rv_counted})
            2'b10:   w_out_nxt = r_out + 2'd1;
            2'b01:   w_out_nxt = r_out - 2'd1;
            default: w_out_nxt = r_out;
        endcase
        if (w_accept || mem_rvalid || (r_out == 2'd0)) begin
            w_tmo_nxt = '0;
        end else if (r_tmo != TMO_LAST) begin
            w_tmo_nxt = r_tmo + TW'(1);
        end else begin
            w_tmo_nxt = r_tmo;  // saturate; fault already raised from here
        end
    end

    // Next-state logic and first-cause fault recording.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_fault_nxt = r_fault;
        case (r_state)
            ST_FAULT: begin
                if (fault_clr && (r_out == 2'd0) && !cmp_fault) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_NONE;
                    w_fault_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_IDLE, ST_BUSY: begin
                if (cmp_fault) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_CMP;
                    w_fault_nxt = 1'b1;
                end else if (w_unexp) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_UNEX;
                    w_fault_nxt = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_TMO;
                    w_fault_nxt = 1'b1;
                end else if (w_out_nxt == 2'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = CODE_NONE;
                w_fault_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= 2'd0;
            r_tmo   <= '0;
            r_code  <= CODE_NONE;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_tmo   <= w_tmo_nxt;
            r_code  <= w_code_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Response pipeline stage; data only moves on a valid response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= mem_rvalid;
            if (mem_rvalid) begin
                r_rdata <= mem_rdata;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

endmodule
